// File: rtl/seg_scan_capture.sv
// Passive multiplexed 7-segment bus receiver: settles each scanned digit, decodes it to BCD
// and publishes coherent frames. Optional macro SEG_CAPTURE_DP_EN captures decimal points.
module seg_scan_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int FRAME_TIMEOUT = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              cs,
    input  logic [7:0]              seg,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic                    frame_valid,
    output logic [NUM_DIGITS-1:0]   seg_err,
    output logic                    stale
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(FRAME_TIMEOUT);

`ifdef SEG_CAPTURE_DP_EN
    localparam int SEG_W = 8;
`else
    localparam int SEG_W = 7;
    logic w_unused_dp;
    assign w_unused_dp = seg[7];
`endif

    typedef enum logic [1:0] {ST_WAIT, ST_SETTLE, ST_HOLD} state_t;

    logic [7:0]            r_cs_meta, r_cs_sync, r_cs_prev;
    logic [SEG_W-1:0]      r_seg_meta, r_seg_sync;
    state_t                r_state, w_state_next;
    logic [SW-1:0]         r_settle_cnt, w_cnt_next;
    logic [TW-1:0]         r_to_cnt;
    logic [NUM_DIGITS-1:0] r_seen, w_hit;
    logic                  r_frame_valid;
    logic                  w_cs_change, w_take, w_accept, w_sample, w_full;
    logic [3:0]            w_zeros;
    logic [2:0]            w_idx;
    logic [3:0]            w_dec_val;
    logic                  w_dec_err;

    // Returns {err, value}; seg is active-high here
    function automatic logic [4:0] decode7(input logic [6:0] p);
        case (p)
            7'h3F: decode7 = 5'h00;
            7'h06: decode7 = 5'h01;
            7'h5B: decode7 = 5'h02;
            7'h4F: decode7 = 5'h03;
            7'h66: decode7 = 5'h04;
            7'h6D: decode7 = 5'h05;
            7'h7D: decode7 = 5'h06;
            7'h07: decode7 = 5'h07;
            7'h7F: decode7 = 5'h08;
            7'h6F: decode7 = 5'h09;
            7'h00: decode7 = 5'h0F;
            default: decode7 = 5'h1E;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_meta  <= 8'hFF;
            r_cs_sync  <= 8'hFF;
            r_cs_prev  <= 8'hFF;
            r_seg_meta <= '1;
            r_seg_sync <= '1;
        end else begin
            r_cs_meta  <= cs;
            r_cs_sync  <= r_cs_meta;
            r_cs_prev  <= r_cs_sync;
            r_seg_meta <= ~seg[SEG_W-1:0];
            r_seg_sync <= r_seg_meta;
        end
    end

    assign w_cs_change = (r_cs_sync != r_cs_prev);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_settle_cnt;
        w_take       = 1'b0;
        if (w_cs_change) begin
            w_state_next = ST_SETTLE;
            w_cnt_next   = '0;
        end else if (r_state == ST_SETTLE) begin
            w_cnt_next = r_settle_cnt + 1'b1;
            if (w_cnt_next == SETTLE_MAX) begin
                w_take       = 1'b1;
                w_state_next = ST_HOLD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_WAIT;
            r_settle_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_settle_cnt <= w_cnt_next;
        end
    end

    // Sample is valid only for a single active-low select within range
    always_comb begin
        w_zeros = 4'd0;
        w_idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!r_cs_sync[i]) begin
                w_zeros = w_zeros + 4'd1;
                w_idx   = 3'(i);
            end
        end
    end

    assign w_accept = (w_zeros == 4'd1) && (int'(w_idx) < NUM_DIGITS);
    assign w_sample = w_take && w_accept;
    assign {w_dec_err, w_dec_val} = decode7(r_seg_sync[6:0]);
    assign w_full = &r_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seen        <= '0;
            r_frame_valid <= 1'b0;
            r_to_cnt      <= '0;
        end else begin
            r_seen        <= (w_full ? '0 : r_seen) | w_hit;
            r_frame_valid <= w_full;
            if (w_full)
                r_to_cnt <= '0;
            else if (r_to_cnt != TIMEOUT_MAX)
                r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] r_shadow_val, r_out_val;
            logic       r_shadow_err, r_out_err;

            assign w_hit[gi] = w_sample && (w_idx == 3'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_shadow_val <= '0;
                    r_shadow_err <= 1'b0;
                    r_out_val    <= '0;
                    r_out_err    <= 1'b0;
                end else begin
                    if (w_hit[gi]) begin
                        r_shadow_val <= w_dec_val;
                        r_shadow_err <= w_dec_err;
                    end
                    if (w_full) begin
                        r_out_val <= r_shadow_val;
                        r_out_err <= r_shadow_err;
                    end
                end
            end

            assign digits[4*gi +: 4] = r_out_val;
            assign seg_err[gi]       = r_out_err;

`ifdef SEG_CAPTURE_DP_EN
            logic r_shadow_dp, r_out_dp;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_shadow_dp <= 1'b0;
                    r_out_dp    <= 1'b0;
                end else begin
                    if (w_hit[gi])
                        r_shadow_dp <= r_seg_sync[7];
                    if (w_full)
                        r_out_dp <= r_shadow_dp;
                end
            end
            assign dp[gi] = r_out_dp;
`endif
        end
    endgenerate

`ifndef SEG_CAPTURE_DP_EN
    assign dp = '0;
`endif

    assign frame_valid = r_frame_valid;
    assign stale       = (r_to_cnt == TIMEOUT_MAX);

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: scans digit patterns and checks published frames.
module tb_seg_scan_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cs, seg;
    logic [15:0] digits;
    logic [3:0]  dp, seg_err;
    logic        frame_valid, stale;

    int tests = 0;
    int fails = 0;
    int fv_count = 0;

`ifdef SEG_CAPTURE_DP_EN
    localparam logic [3:0] EXP_DP0 = 4'b0001;
`else
    localparam logic [3:0] EXP_DP0 = 4'b0000;
`endif

    seg_scan_capture #(
        .NUM_DIGITS(4),
        .SETTLE_CYCLES(4),
        .FRAME_TIMEOUT(300)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cs(cs),
        .seg(seg),
        .digits(digits),
        .dp(dp),
        .frame_valid(frame_valid),
        .seg_err(seg_err),
        .stale(stale)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid === 1'b1)
            fv_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[TB] check %s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic scan(input logic [7:0] c, input logic [7:0] s, input int dwell);
        cs  = c;
        seg = s;
        repeat (dwell) @(negedge clk);
    endtask

    task automatic scan_frame(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
        scan(8'hFE, s0, 10);
        scan(8'hFD, s1, 10);
        scan(8'hFB, s2, 10);
        scan(8'hF7, s3, 10);
        scan(8'hFF, 8'hFF, 10);
    endtask

    initial begin
        rst = 1'b1;
        cs  = 8'hFF;
        seg = 8'hFF;
        repeat (3) @(negedge clk);
        check("reset_digits", 32'(digits), 32'h0);
        check("reset_dp", 32'(dp), 32'h0);
        check("reset_seg_err", 32'(seg_err), 32'h0);
        check("reset_frame_valid", 32'(frame_valid), 32'h0);
        check("reset_stale", 32'(stale), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame: 0,1,2,5
        scan_frame(8'hC0, 8'hF9, 8'hA4, 8'h92);
        check("f1_count", 32'(fv_count), 32'd1);
        check("f1_digits", 32'(digits), 32'h5210);
        check("f1_seg_err", 32'(seg_err), 32'h0);
        check("f1_dp", 32'(dp), 32'h0);

        // Short dwell on digit 2 must not complete the frame
        scan(8'hFE, 8'hB0, 10);
        scan(8'hFD, 8'h99, 10);
        scan(8'hFB, 8'hF8, 3);
        scan(8'hF7, 8'h80, 10);
        scan(8'hFF, 8'hFF, 10);
        check("short_no_frame", 32'(fv_count), 32'd1);
        scan(8'hFB, 8'h90, 10);
        scan(8'hFF, 8'hFF, 10);
        check("short_then_full_count", 32'(fv_count), 32'd2);
        check("short_then_full_digits", 32'(digits), 32'h8943);

        // Undecodable pattern on digit 1, then a clean frame
        scan_frame(8'hC0, 8'hAA, 8'hA4, 8'h92);
        check("err_count", 32'(fv_count), 32'd3);
        check("err_digits", 32'(digits), 32'h52E0);
        check("err_seg_err", 32'(seg_err), 32'h2);
        scan_frame(8'hC0, 8'hF9, 8'hA4, 8'h92);
        check("clean_count", 32'(fv_count), 32'd4);
        check("clean_digits", 32'(digits), 32'h5210);
        check("clean_seg_err", 32'(seg_err), 32'h0);

        // Blank, double-select and out-of-range selects interleaved; digit 2 blank segments
        scan(8'hFE, 8'hF9, 10);
        scan(8'hFF, 8'hC0, 10);
        scan(8'hFD, 8'hA4, 10);
        scan(8'hFC, 8'h92, 10);
        scan(8'hFB, 8'hFF, 10);
        scan(8'hEF, 8'h80, 10);
        scan(8'hFC, 8'h80, 10);
        scan(8'hF7, 8'hC0, 10);
        scan(8'hFF, 8'hFF, 10);
        check("ilv_count", 32'(fv_count), 32'd5);
        check("ilv_digits", 32'(digits), 32'h0F21);
        check("ilv_seg_err", 32'(seg_err), 32'h0);

        // Timeout
        check("stale_before", 32'(stale), 32'h0);
        repeat (320) @(negedge clk);
        check("stale_set", 32'(stale), 32'h1);
        scan(8'hFE, 8'h80, 10);
        check("stale_held_midframe", 32'(stale), 32'h1);
        scan(8'hFD, 8'h90, 10);
        scan(8'hFB, 8'hC0, 10);
        scan(8'hF7, 8'hF9, 10);
        scan(8'hFF, 8'hFF, 10);
        check("stale_cleared", 32'(stale), 32'h0);
        check("stale_count", 32'(fv_count), 32'd6);
        check("stale_digits", 32'(digits), 32'h1098);

        // Reset with two digits captured
        scan(8'hFE, 8'hB0, 10);
        scan(8'hFD, 8'h99, 10);
        scan(8'hFF, 8'hFF, 2);
        rst = 1'b1;
        #1;
        check("rst_mid_digits", 32'(digits), 32'h0);
        check("rst_mid_frame_valid", 32'(frame_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        scan(8'hFB, 8'hA4, 10);
        scan(8'hF7, 8'h92, 10);
        scan(8'hFF, 8'hFF, 10);
        check("rst_partial_discarded", 32'(fv_count), 32'd6);
        scan(8'hFE, 8'hC0, 10);
        scan(8'hFD, 8'hF9, 10);
        scan(8'hFF, 8'hFF, 10);
        check("rst_post_count", 32'(fv_count), 32'd7);
        check("rst_post_digits", 32'(digits), 32'h5210);

        // Decimal point on digit 0 does not disturb decoding
        scan_frame(8'h40, 8'hF9, 8'hA4, 8'h92);
        check("dp_count", 32'(fv_count), 32'd8);
        check("dp_digits", 32'(digits), 32'h5210);
        check("dp_value", 32'(dp), 32'(EXP_DP0));
        check("dp_seg_err", 32'(seg_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Passive receiver for the multiplexed 7-segment display bus that our display controllers drive. It watches the digit-select and segment lines, waits for each scanned digit to settle, decodes the segment pattern back to a BCD value, and publishes a coherent 4-digit frame once every digit has been seen. It is used in verification harnesses and on-chip self-check to read back what a display block is showing, for example the traffic-light countdown and counter digits.

## Interface
- `NUM_DIGITS`, 4: scanned digit positions captured, 1..8; cs indices >= NUM_DIGITS are ignored.
- `SETTLE_CYCLES`, 4: clk cycles a cs value must be stable before the segments are sampled, >= 1.
- `FRAME_TIMEOUT`, 100000: clk cycles without a completed frame before `stale` asserts.
- `clk`  in  1: single clock; all logic runs on its rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `cs`  in  8: digit select, active-low one-hot; bit i selects digit i. Asynchronous to clk.
- `seg`  in  8: segments, active-low, order {dp,g,f,e,d,c,b,a}. Asynchronous to clk.
- `digits`  out  4*NUM_DIGITS: captured values; digit i occupies bits [4i+3:4i].
- `dp`  out  NUM_DIGITS: captured decimal-point state, 1 = lit.
- `frame_valid`  out  1: one-cycle pulse when `digits`/`dp` update.
- `seg_err`  out  NUM_DIGITS: per-digit flag; 1 = that digit held an undecodable pattern in the last published frame.
- `stale`  out  1: no frame completed within FRAME_TIMEOUT cycles.

## Operation
- `cs` and `seg` each pass through a 2-flop synchronizer; all logic below uses the synchronized copies.
- FSM states:
  - WAIT: waiting for a cs change.
  - SETTLE: counting stability.
  - HOLD: this cs value has already been sampled.
  - Any change of the synchronized cs in any state goes to SETTLE and clears the settle counter.
  - SETTLE counts up. When it reaches SETTLE_CYCLES, one sample is taken and the FSM goes to HOLD.
  - Each distinct cs dwell is therefore sampled exactly once.
- A sample is accepted only when cs has exactly one zero bit at an index < NUM_DIGITS. All-ones (blanking), multiple zeros, or an out-of-range index: no sample, FSM goes to HOLD.
- Decode uses the active-high seg[6:0] pattern:
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9.
  - All segments off → 4'hF, no error.
  - Any other pattern → 4'hE and the error bit set.
- An accepted sample writes the shadow value, shadow dp, and shadow error bit for its index, and sets that index's bit in the seen mask. A re-scan of an already-seen index overwrites the shadow.
- When the seen mask becomes all ones:
  - The next cycle copies the shadow to `digits`/`dp`/`seg_err`, pulses `frame_valid`, and clears the mask and the timeout counter.
- Timeout counter: increments every cycle and saturates at FRAME_TIMEOUT. `stale` = (counter == FRAME_TIMEOUT). `stale` clears on the next `frame_valid`.

## Timing
- Reset values:
  - `digits` = 0, `dp` = 0, `seg_err` = 0, `frame_valid` = 0, `stale` = 0.
  - FSM = WAIT, seen mask = 0, counters = 0.
- Latency from a cs edge at the pins to the sample: 2 synchronizer cycles + SETTLE_CYCLES, ±1 for asynchronous input alignment.
- Latency from the last digit's sample to `frame_valid`: 1 cycle. `digits` is valid in the same cycle as `frame_valid`.
- A cs dwell shorter than SETTLE_CYCLES after synchronization is never sampled.
- A sample completing the mask in the same cycle that the timeout saturates: the frame publishes, and `stale` is 0 in the following cycle.
- Reset asserted mid-frame: the partial shadow and mask are discarded, and outputs return to reset values immediately.

## Configuration
- `SEG_CAPTURE_DP_EN` defined: seg[7] is captured per digit into `dp`.
- Undefined:
  - seg[7] is ignored.
  - `dp` is tied to 0.
  - No dp shadow storage is built.
- Decoding is independent of seg[7] in both cases.

## Test plan
- Scan cs FE/FD/FB/F7 with seg C0/F9/A4/92, 1 kHz-equivalent dwell → `frame_valid` once; `digits` = 16'h5210 (digit3=5 … digit0=0), `seg_err` = 0.
- Dwell of SETTLE_CYCLES-1 cycles on digit 2 within an otherwise valid scan → no sample for index 2; `frame_valid` withheld until a full-length dwell on digit 2.
- seg = 0xAA on digit 1 → digit1 = 4'hE and `seg_err`[1] = 1 in the published frame; the next clean frame clears it.
- Interleave cs = FF (blank) and cs = FC (two active) between digits → both ignored; frame content unchanged.
- Stop scanning for FRAME_TIMEOUT cycles → `stale` = 1; resume the scan → `stale` = 0 at the next `frame_valid`.
- Assert `rst` after 2 digits captured, release, scan 4 digits → exactly one `frame_valid`, with values only from the post-reset scan. With `SEG_CAPTURE_DP_EN`, seg = 0x40 on digit 0 → digit0 = 0 and `dp`[0] = 1.
